// File: rtl/vec_wb_serializer.sv
// Vector writeback serializer: accepts one LMUL-grouped result and drains it into the
// single-register write port of vec_regfile, one VLEN-bit register per cycle.
// Optional feature: define VEC_WB_MASK_EN to forward the captured byte enables on rf_wr_be;
// when undefined, result_be is ignored and rf_wr_be is all ones on every write.
module vec_wb_serializer #(
    parameter int unsigned VLEN       = 512,
    parameter int unsigned MAX_LMUL   = 8,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         result_valid,
    output logic                         result_ready,
    input  logic [VLEN*MAX_LMUL-1:0]     result_data,
    input  logic [REG_ADDR_W-1:0]        result_vd,
    input  logic [3:0]                   result_lmul,
    input  logic [VLEN*MAX_LMUL/8-1:0]   result_be,
    input  logic                         rf_stall,
    output logic                         rf_wr_en,
    output logic [REG_ADDR_W-1:0]        rf_waddr,
    output logic [VLEN-1:0]              rf_wdata,
    output logic [VLEN/8-1:0]            rf_wr_be,
    output logic                         wb_done,
    output logic                         wb_error,
    output logic [REG_ADDR_W-1:0]        wb_vd
);

    localparam int unsigned DataW   = VLEN * MAX_LMUL;
    localparam int unsigned LaneBeW = VLEN / 8;
    localparam int unsigned NumRegs = 1 << REG_ADDR_W;

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    state_e                  state_q, state_d;
    logic [2:0]              beat_q, beat_d;
    logic [REG_ADDR_W-1:0]   vd_q;
    logic [3:0]              lmul_q;
    logic [DataW-1:0]        data_q;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [REG_ADDR_W-1:0]   wb_vd_q, wb_vd_d;
    logic                    accept;
    logic                    legal;
    logic                    last_beat;

`ifdef VEC_WB_MASK_EN
    logic [DataW/8-1:0]      be_q;
`else
    logic                    unused_be;
    assign unused_be = ^result_be;
`endif

    assign accept    = result_valid && (state_q == StIdle);
    assign last_beat = (beat_q == 3'(lmul_q - 4'd1));

    // Group legality: power-of-two size, base aligned to size, group fits the register file.
    // Sizes beyond MAX_LMUL are rejected so the beat slice never leaves the data bus.
    always_comb begin
        legal = 1'b0;
        case (result_lmul)
            4'd1, 4'd2, 4'd4, 4'd8: begin
                legal = (32'(result_lmul) <= MAX_LMUL)
                     && ((result_vd & REG_ADDR_W'(result_lmul - 4'd1)) == '0)
                     && (32'(result_vd) + 32'(result_lmul) <= NumRegs);
            end
            default: legal = 1'b0;
        endcase
    end

    // Next-state, beat sequencing, completion/error pulses and register-file outputs.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        wb_vd_d      = wb_vd_q;
        result_ready = (state_q == StIdle);
        rf_wr_en     = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        rf_wr_be     = '0;
        unique case (state_q)
            StIdle: begin
                if (result_valid) begin
                    if (legal) begin
                        state_d = StWrite;
                        beat_d  = 3'd0;
                    end else begin
                        error_d = 1'b1;
                        wb_vd_d = result_vd;
                    end
                end
            end
            StWrite: begin
                rf_wr_en = !rf_stall;
                rf_waddr = vd_q + REG_ADDR_W'(beat_q);
                rf_wdata = data_q[32'(beat_q) * VLEN +: VLEN];
`ifdef VEC_WB_MASK_EN
                rf_wr_be = be_q[32'(beat_q) * LaneBeW +: LaneBeW];
`else
                rf_wr_be = {LaneBeW{!rf_stall}};
`endif
                if (!rf_stall) begin
                    if (last_beat) begin
                        state_d = StIdle;
                        beat_d  = 3'd0;
                        done_d  = 1'b1;
                        wb_vd_d = vd_q;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state and registered status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            beat_q  <= 3'd0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            wb_vd_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            error_q <= error_d;
            wb_vd_q <= wb_vd_d;
        end
    end

    // Holding registers for the accepted group; upstream is free to move on afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vd_q   <= '0;
            lmul_q <= '0;
            data_q <= '0;
`ifdef VEC_WB_MASK_EN
            be_q   <= '0;
`endif
        end else if (accept) begin
            vd_q   <= result_vd;
            lmul_q <= result_lmul;
            data_q <= result_data;
`ifdef VEC_WB_MASK_EN
            be_q   <= result_be;
`endif
        end
    end

    assign wb_done  = done_q;
    assign wb_error = error_q;
    assign wb_vd    = wb_vd_q;

endmodule

// File: tb/tb_vec_wb_serializer.sv
// Testbench for vec_wb_serializer: directed scenarios plus randomized groups, checked by a
// scoreboard monitor against expectations derived from the group rules.
module tb_vec_wb_serializer;

    localparam int unsigned VLEN     = 512;
    localparam int unsigned MAX_LMUL = 8;
    localparam int unsigned AW       = 5;
    localparam int unsigned DW       = VLEN * MAX_LMUL;
    localparam int unsigned BW       = DW / 8;
    localparam int unsigned LBW      = VLEN / 8;

    logic            clk;
    logic            reset;
    logic            result_valid;
    logic            result_ready;
    logic [DW-1:0]   result_data;
    logic [AW-1:0]   result_vd;
    logic [3:0]      result_lmul;
    logic [BW-1:0]   result_be;
    logic            rf_stall;
    logic            rf_wr_en;
    logic [AW-1:0]   rf_waddr;
    logic [VLEN-1:0] rf_wdata;
    logic [LBW-1:0]  rf_wr_be;
    logic            wb_done;
    logic            wb_error;
    logic [AW-1:0]   wb_vd;

    vec_wb_serializer #(
        .VLEN       (VLEN),
        .MAX_LMUL   (MAX_LMUL),
        .REG_ADDR_W (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data),
        .result_vd    (result_vd),
        .result_lmul  (result_lmul),
        .result_be    (result_be),
        .rf_stall     (rf_stall),
        .rf_wr_en     (rf_wr_en),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_wr_be     (rf_wr_be),
        .wb_done      (wb_done),
        .wb_error     (wb_error),
        .wb_vd        (wb_vd)
    );

    typedef struct {
        logic [AW-1:0]   addr;
        logic [VLEN-1:0] data;
        logic [LBW-1:0]  be;
        bit              last;
    } wr_t;

    typedef struct {
        bit            is_err;
        logic [AW-1:0] vd;
        int            due;
    } ev_t;

    wr_t wq[$];
    ev_t eq[$];
    int  cyc = 0;
    int  done_due = -1;
    int  last_done_cyc = -1;
    int  checks = 0;
    int  errors = 0;
    bit  stall_en = 0;
    logic [LBW-1:0] mon_be;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Random register-file back-pressure when enabled.
    always @(posedge clk) begin
        #1;
        if (stall_en) rf_stall = ($urandom % 4 == 0);
    end

    task automatic check(input string name, input logic [VLEN-1:0] act,
                         input logic [VLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_legal(input int lmul, input int vd);
        return (lmul == 1 || lmul == 2 || lmul == 4 || lmul == 8)
            && (vd % lmul == 0) && (vd + lmul <= 32);
    endfunction

    function automatic logic [LBW-1:0] model_be(input logic [BW-1:0] b, input int k);
`ifdef VEC_WB_MASK_EN
        return b[k*LBW +: LBW];
`else
        return {LBW{1'b1}};
`endif
    endfunction

    // Issue one group; expectations are queued when the handshake completes.
    task automatic send(input int lmul, input int vd, input logic [DW-1:0] d,
                        input logic [BW-1:0] b, output int acc);
        int n;
        ev_t ev;
        wr_t w;
        acc = -1;
        @(negedge clk);
        result_valid = 1'b1;
        result_lmul  = 4'(lmul);
        result_vd    = AW'(vd);
        result_data  = d;
        result_be    = b;
        n = 0;
        while (!result_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                errors++;
                $display("FAIL accept_timeout: ready stayed 0 for %0d cycles", n);
                result_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        if (is_legal(lmul, vd)) begin
            for (int k = 0; k < lmul; k++) begin
                w.addr = AW'(vd + k);
                w.data = d[k*VLEN +: VLEN];
                w.be   = model_be(b, k);
                w.last = (k == lmul - 1);
                wq.push_back(w);
            end
        end
        #1;
        acc = cyc;
        ev.is_err = !is_legal(lmul, vd);
        ev.vd     = AW'(vd);
        ev.due    = ev.is_err ? acc : -1;
        eq.push_back(ev);
        result_valid = 1'b0;
        result_data  = {DW{1'b1}};
        result_vd    = '1;
        result_lmul  = 4'd8;
        result_be    = '0;
    endtask

    task automatic rand_data(output logic [DW-1:0] d);
        for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
    endtask

    task automatic rand_be(output logic [BW-1:0] b);
        for (int i = 0; i < int'(BW / 32); i++) b[i*32 +: 32] = $urandom;
    endtask

    // Scoreboard monitor: compares every output against the queued expectations.
    always @(negedge clk) begin
        if (reset) begin
            bit exp_done;
            bit exp_err;
            exp_done = (done_due == cyc);
            exp_err  = (eq.size() > 0) && eq[0].is_err && (eq[0].due == cyc);
            check("wb_done", wb_done, exp_done);
            check("wb_error", wb_error, exp_err);
            if (wb_done) last_done_cyc = cyc;
            if (exp_done) begin
                if (eq.size() > 0 && !eq[0].is_err) begin
                    check("done_vd", wb_vd, eq[0].vd);
                    void'(eq.pop_front());
                end else begin
                    errors++;
                    $display("FAIL done_event: completion expected but none queued");
                end
                done_due = -1;
            end else if (exp_err) begin
                check("error_vd", wb_vd, eq[0].vd);
                void'(eq.pop_front());
            end
            if (wq.size() > 0) begin
`ifdef VEC_WB_MASK_EN
                mon_be = wq[0].be;
`else
                mon_be = rf_stall ? '0 : wq[0].be;
`endif
                check("ready_busy", result_ready, 1'b0);
                check("wr_en", rf_wr_en, !rf_stall);
                check("waddr", rf_waddr, wq[0].addr);
                check("wdata", rf_wdata, wq[0].data);
                check("wr_be", rf_wr_be, mon_be);
                if (!rf_stall) begin
                    if (wq[0].last) done_due = cyc + 1;
                    void'(wq.pop_front());
                end
            end else begin
                check("ready_idle", result_ready, 1'b1);
                check("idle_wr_en", rf_wr_en, 1'b0);
                check("idle_waddr", rf_waddr, '0);
                check("idle_wdata", rf_wdata, '0);
                check("idle_wr_be", rf_wr_be, '0);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (wq.size() > 0 || eq.size() > 0 || done_due >= cyc) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                errors++;
                $display("FAIL drain_timeout: %0d writes %0d events outstanding",
                         wq.size(), eq.size());
                wq.delete();
                eq.delete();
                done_due = -1;
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic reset_outputs_check(input string tag);
        check({tag, "_ready"}, result_ready, 1'b1);
        check({tag, "_wr_en"}, rf_wr_en, 1'b0);
        check({tag, "_waddr"}, rf_waddr, '0);
        check({tag, "_wdata"}, rf_wdata, '0);
        check({tag, "_wr_be"}, rf_wr_be, '0);
        check({tag, "_done"}, wb_done, 1'b0);
        check({tag, "_error"}, wb_error, 1'b0);
        check({tag, "_vd"}, wb_vd, '0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [BW-1:0] b;
        int acc;
        int acc2;
        int n;
        int lmul;
        int vd;

        reset        = 1'b0;
        result_valid = 1'b0;
        result_data  = '0;
        result_vd    = '0;
        result_lmul  = '0;
        result_be    = '0;
        rf_stall     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_outputs_check("rst");
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Single register group.
        d = '0;
        d[31:0] = 32'hDEADBEEF;
        rand_be(b);
        send(1, 5, d, b, acc);
        drain();
        check("lmul1_done_cycle", 32'(last_done_cyc), 32'(acc + 1));

        // Full LMUL=8 group, slice k holds k+1.
        d = '0;
        for (int k = 0; k < 8; k++) d[k*VLEN +: VLEN] = VLEN'(k + 1);
        send(8, 8, d, '1, acc);
        drain();
        check("lmul8_done_cycle", 32'(last_done_cyc), 32'(acc + 8));

        // LMUL=4 with a two-cycle stall while beat 1 is presented.
        rand_data(d);
        send(4, 4, d, '1, acc);
        n = 0;
        while (wq.size() != 3 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        rf_stall = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rf_stall = 1'b0;
        drain();
        check("stall_done_cycle", 32'(last_done_cyc), 32'(acc + 6));

        // Illegal groups: misaligned, non power of two, overflowing the file.
        send(4, 6, d, '1, acc);
        send(3, 0, d, '1, acc);
        send(8, 28, d, '1, acc);
        drain();

        // Byte-enable slice followed by a back-to-back group accepted in the done cycle.
        rand_data(d);
        rand_be(b);
        b[LBW-1:0] = LBW'(64'hF);
        send(2, 2, d, b, acc);
        rand_data(d);
        send(1, 0, d, '1, acc2);
        check("b2b_accept_in_done", 32'(acc2), 32'(last_done_cyc + 1));
        drain();

        // Reset pulled while beat 2 of an LMUL=8 group is presented.
        rand_data(d);
        send(8, 16, d, '1, acc);
        n = 0;
        while (wq.size() != 6 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        reset = 1'b0;
        wq.delete();
        eq.delete();
        done_due = -1;
        #1;
        reset_outputs_check("midrst");
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        rand_data(d);
        send(2, 30, d, '1, acc);
        drain();

        // Randomized groups with random back-pressure.
        stall_en = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom % 5 == 0) lmul = $urandom % 16;
            else lmul = 1 << ($urandom % 4);
            vd = $urandom % 32;
            if ((lmul == 1 || lmul == 2 || lmul == 4 || lmul == 8) && ($urandom % 4 != 0))
                vd = vd - (vd % lmul);
            rand_data(d);
            rand_be(b);
            send(lmul, vd, d, b, acc);
            repeat ($urandom % 3) @(negedge clk);
        end
        drain();
        stall_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_wb_serializer.md
# vec_wb_serializer

Writeback stage directly upstream of `vec_regfile`. Accepts one LMUL-grouped vector result (up to `MAX_LMUL` registers wide) over a valid/ready handshake. Drains it into the register file's single-register write port, one VLEN-bit register per cycle. Reports completion or an illegal register-group error to the issue logic.

## Interface
Parameters:
- `VLEN`, 512, bits per vector register
- `MAX_LMUL`, 8, largest register group
- `REG_ADDR_W`, 5, register index width (32 registers)

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `result_valid`  in  1  upstream result present
- `result_ready`  out  1  block can accept a result
- `result_data`  in  VLEN*MAX_LMUL  group data; register k occupies bits [(k+1)*VLEN-1 : k*VLEN]
- `result_vd`  in  REG_ADDR_W  base destination register
- `result_lmul`  in  4  group size; legal values 1, 2, 4, 8
- `result_be`  in  VLEN*MAX_LMUL/8  byte enables, same slicing as data
- `rf_stall`  in  1  register file cannot accept a write this cycle
- `rf_wr_en`  out  1  write strobe to register file
- `rf_waddr`  out  REG_ADDR_W  register being written
- `rf_wdata`  out  VLEN  data for `rf_waddr`
- `rf_wr_be`  out  VLEN/8  byte enables for `rf_waddr`
- `wb_done`  out  1  one-cycle pulse: group fully written
- `wb_error`  out  1  one-cycle pulse: illegal group dropped
- `wb_vd`  out  REG_ADDR_W  base register of the completed or dropped group

## Operation
- FSM has two states: IDLE and WRITE. Reset state is IDLE with `beat`=0.
- `result_ready` = (state==IDLE). A transfer occurs on a rising edge where `result_valid && result_ready`.
- On transfer, data, vd, lmul and be are captured into holding registers. Upstream may change its inputs afterwards.
- A group is legal when lmul ∈ {1,2,4,8}, vd % lmul == 0, and vd+lmul ≤ 32.
- Legal transfer: the FSM moves to WRITE with `beat`=0.
- Illegal transfer: the FSM stays in IDLE and no write is issued. Next cycle `wb_error`=1 and `wb_vd`=captured vd.
- In WRITE:
  - `rf_wr_en` = !`rf_stall`.
  - `rf_waddr` = vd_q + beat.
  - `rf_wdata` = data slice `beat`.
  - `rf_wr_be` = be slice `beat`.
- At each edge in WRITE with `rf_stall`=0, `beat` increments.
- When `beat`==lmul_q-1 and the beat completes unstalled, the FSM returns to IDLE and `beat` clears. Next cycle `wb_done`=1 and `wb_vd`=vd_q.
- When `rf_stall`=1, `beat` and all `rf_*` values hold and `rf_wr_en`=0.
- Outside WRITE, `rf_wr_en`=0 and `rf_waddr`, `rf_wdata`, `rf_wr_be` are 0.
- Beat arithmetic: `beat` is 3 bits. `rf_waddr` cannot wrap because legality guarantees vd+beat ≤ 31.

## Timing
- Reset values: `result_ready`=1, `rf_wr_en`=0, `rf_waddr`=0, `rf_wdata`=0, `rf_wr_be`=0, `wb_done`=0, `wb_error`=0, `wb_vd`=0.
- Accept at edge N. Beat 0 is driven during cycle N+1 and written at edge N+1.
- With no stalls, LMUL=L occupies WRITE for L cycles. `wb_done` is high in cycle N+L+1.
- In cycle N+L+1, `result_ready` is already 1, so a new accept can occur at the same edge. Sustained throughput is one group per L+1 cycles.
- Each stalled cycle adds exactly one cycle of latency.
- `wb_done` and `wb_error` are never both high in the same cycle.
- Illegal group: `wb_error` is high in cycle N+1 and `result_ready` stays 1 throughout.
- Reset asserted mid-WRITE: all outputs go to their reset values immediately. Remaining beats are discarded and no `wb_done` is issued.

## Configuration
- `VEC_WB_MASK_EN` defined: `rf_wr_be` carries the captured `result_be` slice as described above.
- `VEC_WB_MASK_EN` undefined: `result_be` is ignored and not stored, and `rf_wr_be` is all ones whenever `rf_wr_en`=1 (0 otherwise). All other behaviour is identical.

## Test plan
- Reset, then LMUL=1, vd=5, data=0xDEADBEEF → `rf_wr_en` for 1 cycle with `rf_waddr`=5 and `rf_wdata`=0xDEADBEEF; `wb_done`=1 and `wb_vd`=5 in the next cycle.
- LMUL=8, vd=8, slice k = k+1 → 8 consecutive writes to r8..r15 with data 1..8; `result_ready`=0 for 8 cycles; `wb_done` in cycle 9.
- LMUL=4, vd=4, `rf_stall` high for 2 cycles during beat 1 → `rf_waddr` holds 5 with `rf_wr_en`=0 for those cycles; total of 4 writes; `wb_done` delayed by 2 cycles.
- Illegal groups (LMUL=4 vd=6; LMUL=3 vd=0; LMUL=8 vd=28) → no `rf_wr_en`; `wb_error`=1 for one cycle with `wb_vd`=6, 0, 28.
- LMUL=2 vd=2, be slice 0=0x...000F (low 4 bytes only), back-to-back with LMUL=1 vd=0 → `rf_wr_be`=0x...000F on beat 0 with macro, all ones without; second group accepted in the `wb_done` cycle.
- Reset deasserted→asserted during beat 2 of LMUL=8 → `rf_wr_en`=0 and `result_ready`=1 immediately; no `wb_done`; next accepted group writes normally.
